// File: rtl/ddr2_pkg.sv
// Shared definitions for the DDR2 init-sequence monitor.
// Holds the command encodings, the FSM state enum, the error codes and
// the mode-register field offsets.
package ddr2_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_LM   = 4'b0000;

    // Each state is named by the command it expects next. The declaration
    // order is the init order, so "advance" is simply state + 1.
    typedef enum logic [3:0] {
        S_CKE_LOW,
        S_STABLE,
        S_PRE1,
        S_EMR2,
        S_EMR3,
        S_EMR1,
        S_MR_DLLRST,
        S_PRE2,
        S_AREF1,
        S_AREF2,
        S_MR,
        S_OCD_DEF,
        S_OCD_EXIT,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_ORDER   = 3'd1;
    localparam logic [2:0] ERR_TIMING  = 3'd2;
    localparam logic [2:0] ERR_EARLY   = 3'd3;
    localparam logic [2:0] ERR_A10     = 3'd4;
    localparam logic [2:0] ERR_ILLEGAL = 3'd5;
    localparam logic [2:0] ERR_CKE     = 3'd6;

    // Mode-register field positions
    localparam int BL_LSB      = 0;   // MR burst length [2:0]
    localparam int CL_LSB      = 4;   // MR CAS latency [6:4]
    localparam int DLL_RST_BIT = 8;   // MR DLL reset
    localparam int DLL_DIS_BIT = 0;   // EMR1 DLL disable
    localparam int AL_LSB      = 3;   // EMR1 additive latency [5:3]
    localparam int OCD_LSB     = 7;   // EMR1 OCD program [9:7]
    localparam int A10_BIT     = 10;  // precharge-all

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ddr2_init_mon_if.sv
// DDR2 command bus as seen between the init sequencer and the PHY.
//   cke  : clock enable
//   cmd  : {cs_n, ras_n, cas_n, we_n}
//   ba   : bank address
//   addr : address
// master = controller side, slave = monitor side.
interface ddr2_init_mon_if #(
    parameter int ADDR_BITS = 14,
    parameter int BA_BITS   = 3
);
    logic                 cke;
    logic [3:0]           cmd;
    logic [BA_BITS-1:0]   ba;
    logic [ADDR_BITS-1:0] addr;

    modport master (output cke, cmd, ba, addr);
    modport slave  (input  cke, cmd, ba, addr);
endinterface

// File: rtl/ddr2_cmd_gap_cnt.sv
// Saturating cycles-since-last-command counter.
//   clk, rst_n : clock, async active-low reset
//   clr        : an accepted command was sampled this cycle
//   cnt        : cycles since that command minus one, saturating at MAX
module ddr2_cmd_gap_cnt #(
    parameter int MAX = 26,
    parameter int W   = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 cnt <= '0;
        else if (clr)               cnt <= '0;
        else if (cnt != W'(MAX))    cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/ddr2_init_mon.sv
// DDR2 power-up initialization monitor.
// Samples the command bus every clock, checks JEDEC init order, CKE
// behaviour, PRE-all A10 and (optionally) inter-command gaps, captures the
// MR/EMR1/EMR2/EMR3 writes and reports completion or a sticky error code.
//   clk, rst_n          : clock, async active-low reset
//   bus (slave)         : cke / cmd / ba / addr from the controller
//   init_done           : sequence finished cleanly (sticky)
//   init_err, err_code  : sticky error flag and first error code
//   mr_q .. emr3_q      : last value written to each mode register
//   cas_lat, burst_len, add_lat : decoded MR/EMR1 fields
// Build option: DDR2_INIT_MON_TCHECK_EN enables gap checking (code 2).
module ddr2_init_mon
    import ddr2_pkg::*;
#(
    parameter int ADDR_BITS = 14,
    parameter int BA_BITS   = 3,
    parameter int T_STABLE  = 100,
    parameter int T_RP      = 3,
    parameter int T_MRD     = 2,
    parameter int T_RFC     = 26
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ddr2_init_mon_if.slave       bus,
    output logic                 init_done,
    output logic                 init_err,
    output logic [2:0]           err_code,
    output logic [ADDR_BITS-1:0] mr_q,
    output logic [ADDR_BITS-1:0] emr1_q,
    output logic [ADDR_BITS-1:0] emr2_q,
    output logic [ADDR_BITS-1:0] emr3_q,
    output logic [2:0]           cas_lat,
    output logic [2:0]           burst_len,
    output logic [2:0]           add_lat
);

    localparam int                STAB_W   = $clog2(T_STABLE + 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(T_STABLE);

    state_t            state, state_nxt;
    logic [STAB_W-1:0] stab_cnt;
    logic [2:0]        err_nxt;
    logic              exp_ok, checked, acc;
    logic              e_order, e_timing, e_early, e_a10, e_illegal, e_cke;

    logic is_nop, is_pre, is_aref, is_lm, legal_enc;
    assign is_nop    = (bus.cmd == CMD_NOP);
    assign is_pre    = (bus.cmd == CMD_PRE);
    assign is_aref   = (bus.cmd == CMD_AREF);
    assign is_lm     = (bus.cmd == CMD_LM);
    assign legal_enc = is_nop | is_pre | is_aref | is_lm;

    // States in which cke must stay high and every command is checked
    assign checked = (state >= S_STABLE) && (state <= S_OCD_EXIT);

`ifdef DDR2_INIT_MON_TCHECK_EN
    localparam int GAP_MAX = max3(T_RP, T_MRD, T_RFC);
    localparam int GAP_W   = $clog2(GAP_MAX + 1);

    logic [GAP_W-1:0] gap_cnt;
    // Minimum legal gap_cnt for the next command; the counter reads N-1
    // when the next command arrives N cycles after the previous one.
    logic [GAP_W-1:0] gap_req;

    ddr2_cmd_gap_cnt #(.MAX(GAP_MAX), .W(GAP_W)) u_gap (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc),
        .cnt   (gap_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            gap_req <= '0;
        else if (acc) begin
            if (is_pre)       gap_req <= GAP_W'(T_RP - 1);
            else if (is_aref) gap_req <= GAP_W'(T_RFC - 1);
            else              gap_req <= GAP_W'(T_MRD - 1);
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        exp_ok    = 1'b0;
        e_order   = 1'b0;
        e_timing  = 1'b0;
        e_early   = 1'b0;
        e_a10     = 1'b0;
        e_illegal = 1'b0;
        e_cke     = 1'b0;
        err_nxt   = ERR_NONE;

        case (state)
            S_STABLE, S_PRE1, S_PRE2: exp_ok = is_pre;
            S_AREF1, S_AREF2:         exp_ok = is_aref;
            S_EMR2:      exp_ok = is_lm && (bus.ba == BA_BITS'(2));
            S_EMR3:      exp_ok = is_lm && (bus.ba == BA_BITS'(3));
            S_EMR1:      exp_ok = is_lm && (bus.ba == BA_BITS'(1)) && !bus.addr[DLL_DIS_BIT];
            S_MR_DLLRST: exp_ok = is_lm && (bus.ba == BA_BITS'(0)) &&  bus.addr[DLL_RST_BIT];
            S_MR:        exp_ok = is_lm && (bus.ba == BA_BITS'(0)) && !bus.addr[DLL_RST_BIT];
            S_OCD_DEF:   exp_ok = is_lm && (bus.ba == BA_BITS'(1)) && (bus.addr[OCD_LSB +: 3] == 3'b111);
            S_OCD_EXIT:  exp_ok = is_lm && (bus.ba == BA_BITS'(1)) && (bus.addr[OCD_LSB +: 3] == 3'b000);
            default:     exp_ok = 1'b0;
        endcase

        if (state == S_CKE_LOW) begin
            // Any command before CKE has been high for T_STABLE is early
            e_early = !is_nop;
        end else if (checked) begin
            e_cke = !bus.cke;
            if (!is_nop) begin
                e_early   = !bus.cke || (stab_cnt < STAB_MAX);
                e_illegal = !legal_enc;
                e_a10     = is_pre && !bus.addr[A10_BIT];
                e_order   = legal_enc && !exp_ok;
`ifdef DDR2_INIT_MON_TCHECK_EN
                // PRE1 has no predecessor; gaps are checked from EMR2 on
                e_timing  = (state >= S_EMR2) && (gap_cnt < gap_req);
`endif
            end
        end

        if      (e_order)   err_nxt = ERR_ORDER;
        else if (e_timing)  err_nxt = ERR_TIMING;
        else if (e_early)   err_nxt = ERR_EARLY;
        else if (e_a10)     err_nxt = ERR_A10;
        else if (e_illegal) err_nxt = ERR_ILLEGAL;
        else if (e_cke)     err_nxt = ERR_CKE;

        if (err_nxt != ERR_NONE)
            state_nxt = S_ERR;
        else if (state == S_CKE_LOW) begin
            if (bus.cke) state_nxt = S_STABLE;
        end else if (state == S_STABLE) begin
            // Only NOPs survive here; move on once this one completes T_STABLE
            if (stab_cnt >= STAB_MAX - STAB_W'(1)) state_nxt = S_PRE1;
        end else if (checked && !is_nop)
            state_nxt = state_t'(state + 4'd1);
    end

    // A command that passed every check (or any command once done)
    assign acc = (err_nxt == ERR_NONE) && !is_nop && (checked || state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_CKE_LOW;
            stab_cnt  <= '0;
            init_done <= 1'b0;
            init_err  <= 1'b0;
            err_code  <= ERR_NONE;
            mr_q      <= '0;
            emr1_q    <= '0;
            emr2_q    <= '0;
            emr3_q    <= '0;
        end else begin
            state     <= state_nxt;
            init_done <= (state_nxt == S_DONE);

            // The cke-rising NOP counts as the first stable cycle
            if (state == S_CKE_LOW && bus.cke && is_nop)
                stab_cnt <= STAB_W'(1);
            else if (state == S_STABLE && is_nop && stab_cnt != STAB_MAX)
                stab_cnt <= stab_cnt + STAB_W'(1);

            if (err_nxt != ERR_NONE) begin
                init_err <= 1'b1;
                err_code <= err_nxt;
            end

            if (acc && is_lm) begin
                case (bus.ba[1:0])
                    2'd0: mr_q   <= bus.addr;
                    2'd1: emr1_q <= bus.addr;
                    2'd2: emr2_q <= bus.addr;
                    default: emr3_q <= bus.addr;
                endcase
            end
        end
    end

    assign cas_lat   = mr_q[CL_LSB +: 3];
    assign burst_len = mr_q[BL_LSB +: 3];
    assign add_lat   = emr1_q[AL_LSB +: 3];

endmodule

// File: tb/tb_ddr2_init_mon.sv
module tb_ddr2_init_mon;
    import ddr2_pkg::*;

    localparam int AB = 14;
    localparam int BB = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ddr2_init_mon_if #(.ADDR_BITS(AB), .BA_BITS(BB)) bus();

    logic          init_done, init_err;
    logic [2:0]    err_code, cas_lat, burst_len, add_lat;
    logic [AB-1:0] mr_q, emr1_q, emr2_q, emr3_q;

    ddr2_init_mon #(
        .ADDR_BITS(AB), .BA_BITS(BB), .T_STABLE(100),
        .T_RP(3), .T_MRD(2), .T_RFC(26)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .init_done (init_done),
        .init_err  (init_err),
        .err_code  (err_code),
        .mr_q      (mr_q),
        .emr1_q    (emr1_q),
        .emr2_q    (emr2_q),
        .emr3_q    (emr3_q),
        .cas_lat   (cas_lat),
        .burst_len (burst_len),
        .add_lat   (add_lat)
    );

    typedef struct {
        int            cyc;
        string         name;
        logic          done;
        logic          err;
        logic [2:0]    code;
        logic [AB-1:0] mr, e1, e2, e3;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Legal init steps after the stable period: cmd, ba, addr, NOPs after
    localparam logic [3:0]    SC [11] = '{CMD_PRE, CMD_LM, CMD_LM, CMD_LM, CMD_LM, CMD_PRE,
                                          CMD_AREF, CMD_AREF, CMD_LM, CMD_LM, CMD_LM};
    localparam logic [BB-1:0] SB [11] = '{3'd0, 3'd2, 3'd3, 3'd1, 3'd0, 3'd0,
                                          3'd0, 3'd0, 3'd0, 3'd1, 3'd1};
    localparam logic [AB-1:0] SA [11] = '{14'h0400, 14'h0080, 14'h0005, 14'h0018, 14'h0532, 14'h0400,
                                          14'h0000, 14'h0000, 14'h0432, 14'h0398, 14'h0018};
    localparam int            SG [11] = '{2, 1, 1, 1, 1, 2, 25, 25, 1, 1, 1};

    // Monitor: pops an expectation when its cycle comes up and compares
    always @(negedge clk) begin
        exp_t e;
        while (q.size() != 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_cmp++;
            if (e.cyc != cyc || init_done !== e.done || init_err !== e.err ||
                err_code !== e.code || mr_q !== e.mr || emr1_q !== e.e1 ||
                emr2_q !== e.e2 || emr3_q !== e.e3 || cas_lat !== e.mr[6:4] ||
                burst_len !== e.mr[2:0] || add_lat !== e.e1[5:3]) begin
                n_bad++;
                $display("FAIL %s @%0d: got done=%0b err=%0b code=%0d mr=%h e1=%h e2=%h e3=%h cl=%0d bl=%0d al=%0d | want done=%0b err=%0b code=%0d mr=%h e1=%h e2=%h e3=%h (due @%0d)",
                         e.name, cyc, init_done, init_err, err_code, mr_q, emr1_q, emr2_q, emr3_q,
                         cas_lat, burst_len, add_lat, e.done, e.err, e.code, e.mr, e.e1, e.e2, e.e3, e.cyc);
            end
        end
    end

    task automatic expect_out(input string nm, input logic d, input logic er, input logic [2:0] c,
                              input logic [AB-1:0] m, input logic [AB-1:0] x1,
                              input logic [AB-1:0] x2, input logic [AB-1:0] x3);
        exp_t e;
        e.cyc = cyc + 1; e.name = nm; e.done = d; e.err = er; e.code = c;
        e.mr = m; e.e1 = x1; e.e2 = x2; e.e3 = x3;
        q.push_back(e);
    endtask

    task automatic issue(input logic k, input logic [3:0] c, input logic [BB-1:0] b, input logic [AB-1:0] a);
        @(negedge clk);
        bus.cke = k; bus.cmd = c; bus.ba = b; bus.addr = a;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) issue(bus.cke, CMD_NOP, '0, '0);
    endtask

    task automatic power_up(input int n_stable);
        issue(1'b0, CMD_NOP, '0, '0);
        issue(1'b0, CMD_NOP, '0, '0);
        for (int i = 0; i < n_stable; i++) issue(1'b1, CMD_NOP, '0, '0);
    endtask

    task automatic step(input int i);
        issue(1'b1, SC[i], SB[i], SA[i]);
    endtask

    task automatic run_steps(input int from, input int to);
        for (int i = from; i <= to; i++) begin
            step(i);
            nops(SG[i]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.cke = 1'b0; bus.cmd = CMD_NOP; bus.ba = '0; bus.addr = '0;
        expect_out("reset", 0, 0, 3'd0, 14'h0, 14'h0, 14'h0, 14'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got %0d compared", n_cmp);
        $fatal(1);
    end

    initial begin
        bus.cke = 1'b0; bus.cmd = CMD_NOP; bus.ba = '0; bus.addr = '0;
        repeat (2) @(negedge clk);

        // Full legal sequence at exact minimum gaps
        do_reset();
        power_up(100);
        run_steps(0, 2);
        step(3);
        expect_out("emr1_wr", 0, 0, 3'd0, 14'h0, 14'h0018, 14'h0080, 14'h0005);
        nops(SG[3]);
        run_steps(4, 7);
        step(8);
        expect_out("mr_wr", 0, 0, 3'd0, 14'h0432, 14'h0018, 14'h0080, 14'h0005);
        nops(SG[8]);
        step(9);
        expect_out("ocd_def", 0, 0, 3'd0, 14'h0432, 14'h0398, 14'h0080, 14'h0005);
        nops(SG[9]);
        step(10);
        expect_out("done", 1, 0, 3'd0, 14'h0432, 14'h0018, 14'h0080, 14'h0005);
        nops(3);
        expect_out("done_hold", 1, 0, 3'd0, 14'h0432, 14'h0018, 14'h0080, 14'h0005);
        issue(1'b1, CMD_LM, 3'd2, 14'h0111);
        expect_out("done_lm", 1, 0, 3'd0, 14'h0432, 14'h0018, 14'h0111, 14'h0005);
        issue(1'b1, CMD_PRE, 3'd0, 14'h0000);
        expect_out("done_pre_ign", 1, 0, 3'd0, 14'h0432, 14'h0018, 14'h0111, 14'h0005);
        issue(1'b0, 4'b0011, 3'd0, 14'h0000);
        expect_out("done_bad_ign", 1, 0, 3'd0, 14'h0432, 14'h0018, 14'h0111, 14'h0005);

        // PRE after only 99 stable NOPs
        do_reset();
        power_up(99);
        step(0);
        expect_out("early_pre", 0, 1, 3'd3, 14'h0, 14'h0, 14'h0, 14'h0);
        nops(2);
        step(1);
        expect_out("err_sticky", 0, 1, 3'd3, 14'h0, 14'h0, 14'h0, 14'h0);

        // EMR3 before EMR2, then the rest of the sequence
        do_reset();
        power_up(100);
        run_steps(0, 0);
        step(2);
        expect_out("order", 0, 1, 3'd1, 14'h0, 14'h0, 14'h0, 14'h0);
        nops(1);
        run_steps(1, 10);
        expect_out("order_nodone", 0, 1, 3'd1, 14'h0, 14'h0, 14'h0, 14'h0);

        // EMR1 write with DLL disabled is the wrong command
        do_reset();
        power_up(100);
        run_steps(0, 2);
        issue(1'b1, CMD_LM, 3'd1, 14'h0019);
        expect_out("emr1_a0", 0, 1, 3'd1, 14'h0, 14'h0, 14'h0080, 14'h0005);

        // AREF2 25 cycles after AREF1
        do_reset();
        power_up(100);
        run_steps(0, 5);
        step(6);
        nops(24);
        step(7);
`ifdef DDR2_INIT_MON_TCHECK_EN
        expect_out("aref_gap", 0, 1, 3'd2, 14'h0532, 14'h0018, 14'h0080, 14'h0005);
`else
        expect_out("aref_gap", 0, 0, 3'd0, 14'h0532, 14'h0018, 14'h0080, 14'h0005);
`endif

        // PRE2 without A10
        do_reset();
        power_up(100);
        run_steps(0, 4);
        issue(1'b1, CMD_PRE, 3'd0, 14'h0000);
        expect_out("pre_a10", 0, 1, 3'd4, 14'h0532, 14'h0018, 14'h0080, 14'h0005);

        // cke dropped between AREF1 and AREF2
        do_reset();
        power_up(100);
        run_steps(0, 5);
        step(6);
        nops(3);
        issue(1'b0, CMD_NOP, 3'd0, 14'h0000);
        expect_out("cke_drop", 0, 1, 3'd6, 14'h0532, 14'h0018, 14'h0080, 14'h0005);

        // Illegal encoding (ACT) where EMR2 is expected
        do_reset();
        power_up(100);
        run_steps(0, 0);
        issue(1'b1, 4'b0011, 3'd0, 14'h0000);
        expect_out("illegal", 0, 1, 3'd5, 14'h0, 14'h0, 14'h0, 14'h0);

        // Reset after EMR1, then a full legal sequence
        do_reset();
        power_up(100);
        run_steps(0, 2);
        step(3);
        expect_out("pre_rst", 0, 0, 3'd0, 14'h0, 14'h0018, 14'h0080, 14'h0005);
        nops(SG[3]);
        do_reset();
        power_up(100);
        run_steps(0, 9);
        step(10);
        expect_out("rst_done", 1, 0, 3'd0, 14'h0432, 14'h0018, 14'h0080, 14'h0005);

        nops(3);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL leftover: got %0d unchecked expectations, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
